ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 1, meaning RAM enable cycles per access (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have ports req0/req1, input, 1 each: access request from requester 0 (control_unit) or 1 (loader/debug).
REQ-005 The block SHALL have ports we0/we1, input, 1 each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports addr0/addr1, input, 4 each: RAM word address.
REQ-007 The block SHALL have ports wdata0/wdata1, input, 8 each: write data.
REQ-008 The block SHALL have ports gnt0/gnt1, output, 1 each: requester owns the RAM.
REQ-009 The block SHALL have ports done0/done1, output, 1 each: one-cycle completion pulse.
REQ-010 The block SHALL have port rdata, output, 8: read result, valid in the done cycle and held until the next read completes.
REQ-011 The block SHALL have ports ram_read_en/ram_write_en, output, 1 each; ram_address, output, 4; ram_wdata, output, 8; ram_rdata, input, 8.

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-013 IDLE: if any req is high, the block SHALL choose a winner, register its we/addr/wdata and go to ACCESS; otherwise stay in IDLE.
REQ-014 ACCESS SHALL last exactly ACCESS_CYCLES cycles, driving ram_address/ram_wdata from registers and asserting ram_write_en if we, else ram_read_en.
REQ-015 On the last ACCESS cycle of a read, the block SHALL capture ram_rdata into rdata; writes leave rdata unchanged.
REQ-016 DONE SHALL last one cycle, pulse the owner's done, then go to IDLE.
REQ-017 gntN SHALL be high from the first ACCESS cycle through DONE, for the owner only.
REQ-018 Latency with req high in IDLE cycle 0: enables in cycles 1..ACCESS_CYCLES, done in cycle ACCESS_CYCLES+1.
REQ-019 ram_read_en and ram_write_en SHALL never be high together, and both SHALL be low outside ACCESS.
REQ-020 A req dropped during ACCESS SHALL NOT abort the access; it completes with done.
REQ-021 A req still high in IDLE after DONE SHALL be treated as a new request.
REQ-022 Simultaneous req0 and req1 SHALL be resolved per REQ-027/REQ-028.
REQ-023 Address and data inputs SHALL be sampled only in the IDLE winner cycle; later changes SHALL be ignored.

Reset
REQ-024 While rst is high, the block SHALL force state IDLE, gnt*/done*/ram_read_en/ram_write_en = 0, ram_address = 0, ram_wdata = 0, rdata = 0, cycle counter = 0 and last-winner = 1.
REQ-025 rst asserted mid-ACCESS SHALL deassert RAM enables immediately (asynchronously); the access is abandoned and no done is issued.
REQ-026 After rst falls, the first arbitration SHALL occur in the first IDLE cycle.

Configuration
REQ-027 With RAM_ARB_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the requester not granted last wins; last-winner updates on each grant.
REQ-028 Without RAM_ARB_RR_EN, requester 0 SHALL always win ties and last-winner logic SHALL be absent.

Structure
REQ-029 Package ram_arb_pkg SHALL hold the state typedef (IDLE/ACCESS/DONE), the requester index constants REQ_CPU=0 and REQ_LDR=1, and the address/data width constants 4/8.
REQ-030 Winner selection SHALL be a combinational sub-module ram_arb_picker (inputs req0, req1, last-winner; output winner, valid).
REQ-031 The inout bus of ram is resolved outside this block; this block uses separate wdata/rdata only.

Verification
REQ-032 Single read: ACCESS_CYCLES=1, RAM[0x3]=0x5A; req0=1, we0=0, addr0=3 -> ram_read_en in cycle 1, done0 in cycle 2 with rdata=0x5A, gnt1 never high.
REQ-033 Write then read: req1 writes 0xC3 to addr 0xF, then reads 0xF -> ram_write_en for 1 cycle with ram_wdata=0xC3, then rdata=0xC3.
REQ-034 Contention: req0=req1=1 held for 4 accesses -> with RAM_ARB_RR_EN grants alternate 0,1,0,1; without it, all 4 go to 0.
REQ-035 Multi-cycle: ACCESS_CYCLES=3 -> ram_read_en high exactly 3 cycles, done in cycle 4, enables never both high.
REQ-036 Reset mid-access: rst asserted in cycle 2 of a 3-cycle write -> enables low the same cycle, no done, all outputs 0; after release, a pending req1 is granted first.
REQ-037 Input change: addr0 changed from 0x2 to 0x9 during ACCESS -> ram_address stays 0x2 until done.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arb_picker.sv
// Combinational winner selection between the two requesters.
// RAM_ARB_RR_EN selects round-robin tie-breaking; otherwise requester 0 always wins ties.
module ram_arb_picker
  import ram_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_winner_i,
  output logic winner_o,
  output logic valid_o
);

  assign valid_o = req0_i | req1_i;

`ifdef RAM_ARB_RR_EN
  // NOTE: default assignment first so every path drives winner_o and no latch is inferred.
  always_comb begin
    winner_o = REQ_CPU;
    if (req0_i && req1_i) winner_o = ~last_winner_i;
    else if (req1_i)      winner_o = REQ_LDR;
  end
`else
  logic unused_last_winner;
  assign unused_last_winner = last_winner_i;
  assign winner_o = (req0_i || !req1_i) ? REQ_CPU : REQ_LDR;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: IDLE -> ACCESS (ACCESS_CYCLES) -> DONE, all outputs registered.
// Define RAM_ARB_RR_EN for round-robin tie-breaking (fixed priority to requester 0 otherwise).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               gnt0_q, gnt1_q, done0_q, done1_q;
  logic               rd_en_q, wr_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q, rdata_q;

  logic               pick_winner, pick_valid, last_winner;
  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;

`ifdef RAM_ARB_RR_EN
  logic last_winner_q;
  assign last_winner = last_winner_q;
`else
  assign last_winner = REQ_LDR;
`endif

  ram_arb_picker u_picker (
    .req0_i        (req0),
    .req1_i        (req1),
    .last_winner_i (last_winner),
    .winner_o      (pick_winner),
    .valid_o       (pick_valid)
  );

  assign we_d    = (pick_winner == REQ_LDR) ? we1    : we0;
  assign addr_d  = (pick_winner == REQ_LDR) ? addr1  : addr0;
  assign wdata_d = (pick_winner == REQ_LDR) ? wdata1 : wdata0;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
`ifdef RAM_ARB_RR_EN
      last_winner_q <= REQ_LDR;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= ACCESS;
            cnt_q   <= '0;
            gnt0_q  <= (pick_winner == REQ_CPU);
            gnt1_q  <= (pick_winner == REQ_LDR);
            wr_en_q <= we_d;
            rd_en_q <= !we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef RAM_ARB_RR_EN
            last_winner_q <= pick_winner;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            if (rd_en_q) rdata_q <= ram_rdata;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done0_q <= gnt0_q;
            done1_q <= gnt1_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign rdata        = rdata_q;
  assign ram_read_en  = rd_en_q;
  assign ram_write_en = wr_en_q;
  assign ram_address  = addr_q;
  assign ram_wdata    = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_ram_arbiter;

  localparam int AC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, done0, done1, ram_read_en, ram_write_en;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_address;

  logic [7:0] ram_mem [16];
  logic       bd_we = 1'b0;
  logic [3:0] bd_addr = '0;
  logic [7:0] bd_data = '0;

  logic [7:0] ref_mem [16];
  logic [7:0] exp_rdata;
`ifdef RAM_ARB_RR_EN
  logic       last_w;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .req1         (req1),
    .we0          (we0),
    .we1          (we1),
    .addr0        (addr0),
    .addr1        (addr1),
    .wdata0       (wdata0),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .done0        (done0),
    .done1        (done1),
    .rdata        (rdata),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_address  (ram_address),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  // Simple synchronous-write RAM with a bench backdoor for preloading.
  always @(posedge clk) begin
    if (bd_we)             ram_mem[bd_addr]     <= bd_data;
    else if (ram_write_en) ram_mem[ram_address] <= ram_wdata;
  end
  assign ram_rdata = ram_mem[ram_address];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt0"},  8'(gnt0),         8'h0);
    check({tag, "_gnt1"},  8'(gnt1),         8'h0);
    check({tag, "_done0"}, 8'(done0),        8'h0);
    check({tag, "_done1"}, 8'(done1),        8'h0);
    check({tag, "_rden"},  8'(ram_read_en),  8'h0);
    check({tag, "_wren"},  8'(ram_write_en), 8'h0);
    check({tag, "_addr"},  8'(ram_address),  8'h0);
    check({tag, "_wdata"}, ram_wdata,        8'h0);
    check({tag, "_rdata"}, rdata,            8'h0);
  endtask

  // Model: who should win, given the arbitration rules.
  function automatic logic pick(input logic r0, input logic r1);
    logic w;
    if (r0 && r1) begin
`ifdef RAM_ARB_RR_EN
      w = ~last_w;
`else
      w = 1'b0;
`endif
    end else begin
      w = r1 && !r0;
    end
    return w;
  endfunction

  // Called at a negedge with the DUT idle; runs one whole transaction and ends at the following idle negedge.
  task automatic txn(input logic r0, input logic r1, input logic w0, input logic w1,
                     input logic [3:0] a0, input logic [3:0] a1,
                     input logic [7:0] d0, input logic [7:0] d1, input bit disturb);
    logic       win, wwe;
    logic [3:0] wa;
    logic [7:0] wd, old_rdata;
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    win = pick(r0, r1);
`ifdef RAM_ARB_RR_EN
    last_w = win;
`endif
    wwe = win ? w1 : w0;
    wa  = win ? a1 : a0;
    wd  = win ? d1 : d0;
    old_rdata = exp_rdata;
    if (!wwe) exp_rdata = ref_mem[wa];
    for (int k = 1; k <= AC + 1; k++) begin
      @(negedge clk);
      check("gnt0", 8'(gnt0), 8'(!win));
      check("gnt1", 8'(gnt1), 8'(win));
      check("rd_en", 8'(ram_read_en), 8'(k <= AC && !wwe));
      check("wr_en", 8'(ram_write_en), 8'(k <= AC && wwe));
      check("addr_hold", 8'(ram_address), 8'(wa));
      if (wwe && k <= AC) check("wdata", ram_wdata, wd);
      check("done0", 8'(done0), 8'(k == AC + 1 && !win));
      check("done1", 8'(done1), 8'(k == AC + 1 && win));
      check("rdata", rdata, (k == AC + 1) ? exp_rdata : old_rdata);
      if (disturb) begin
        req0 = 1'b0; req1 = 1'b0;
        we0 = 1'($urandom); we1 = 1'($urandom);
        addr0 = 4'($urandom); addr1 = 4'($urandom);
        wdata0 = 8'($urandom); wdata1 = 8'($urandom);
      end
    end
    if (wwe) ref_mem[wa] = wd;
    @(negedge clk);
    check("idle_gnt", 8'({gnt1, gnt0}), 8'h0);
    check("idle_done", 8'({done1, done0}), 8'h0);
    check("idle_en", 8'({ram_write_en, ram_read_en}), 8'h0);
    check("idle_rdata", rdata, exp_rdata);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    exp_rdata = '0;
`ifdef RAM_ARB_RR_EN
    last_w = 1'b1;
`endif
    // Preload RAM and model while held in reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = 4'(i);
      bd_data = (i == 3) ? 8'h5A : 8'($urandom);
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single read of address 3 by requester 0.
    txn(1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 8'h00, 8'h00, 1'b0);
    // Requester 1 writes 0xC3 to 0xF, then reads it back.
    txn(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 8'h00, 8'hC3, 1'b0);
    txn(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 8'h00, 8'h00, 1'b0);
    check("wr_rd_C3", rdata, 8'hC3);
    // Contention: both requests held across four accesses.
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, 1'b0, 1'b0, 4'(i), 4'(15 - i), 8'h00, 8'h00, 1'b0);
    // Inputs change and requests drop mid-access; the sampled address must hold.
    txn(1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 8'h00, 8'h00, 1'b1);
    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      int unsigned r;
      r = $urandom_range(1, 3);
      txn(1'(r), 1'(r >> 1), 1'($urandom), 1'($urandom),
          4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Reset in the second cycle of a multi-cycle write by requester 1.
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 4'h6; wdata1 = 8'hA7;
    @(negedge clk);
    check("rst_pre_gnt1", 8'(gnt1), 8'h1);
    check("rst_pre_wren", 8'(ram_write_en), 8'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    ref_mem[6] = 8'hA7;
    exp_rdata  = '0;
`ifdef RAM_ARB_RR_EN
    last_w = 1'b1;
`endif
    we1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_done", 8'({done1, done0}), 8'h0);
    end
    rst = 1'b0;
    // Pending requester 1 read is arbitrated in the first idle cycle after reset.
    txn(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h6, 8'h00, 8'h00, 1'b0);
    check("post_rst_rdata", rdata, 8'hA7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
